// File: rtl/led_write_arbiter.sv
// led_write_arbiter
//   Round-robin arbiter that shares one LED PIO slave among NUM_REQ cores.
//   Each core posts a set/clear mask pair; a granted request is merged into
//   the shadow LED image and written to the PIO in a single Avalon write.
//   The shadow is the only copy of the LED state, so the PIO is never read.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   req        [NUM_REQ]   per-core request, held until ack
//   set_mask   [N*W]       core i at [i*W +: W], 1 = LED on
//   clr_mask   [N*W]       same packing, 1 = LED off (set wins on overlap)
//   ack        [NUM_REQ]   one-cycle completion pulse to the granted core
//   address, chipselect, write_n, writedata   Avalon write master to PIO
//   shadow     [W]         LED value as last written
//   busy                   high while a transaction is in flight

// Per-core candidate: the LED value this core's request would produce.
module led_req_lane #(
   parameter int LED_WIDTH = 18
) (
   input  logic [LED_WIDTH-1:0] shadow,
   input  logic [LED_WIDTH-1:0] set_bits,
   input  logic [LED_WIDTH-1:0] clr_bits,
   output logic [LED_WIDTH-1:0] cand
);
   // set is OR-ed last, so a bit in both masks ends up on
   assign cand = (shadow & ~clr_bits) | set_bits;
endmodule

module led_write_arbiter #(
   parameter int NUM_REQ   = 7,
   parameter int LED_WIDTH = 18
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*LED_WIDTH-1:0] set_mask,
   input  logic [NUM_REQ*LED_WIDTH-1:0] clr_mask,
   output logic [NUM_REQ-1:0]           ack,
   output logic [1:0]                   address,
   output logic                         chipselect,
   output logic                         write_n,
   output logic [31:0]                  writedata,
   output logic [LED_WIDTH-1:0]         shadow,
   output logic                         busy
);
   localparam int PW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t                             state, state_nx;
   logic [PW-1:0]                      ptr, gnt, gnt_nx;
   logic                               gnt_found;
   logic [NUM_REQ-1:0][LED_WIDTH-1:0]  cand;

   genvar i;
   generate
      for (i = 0; i < NUM_REQ; i++) begin : g_lane
         led_req_lane #(.LED_WIDTH(LED_WIDTH)) u_lane (
            .shadow   (shadow),
            .set_bits (set_mask[i*LED_WIDTH +: LED_WIDTH]),
            .clr_bits (clr_mask[i*LED_WIDTH +: LED_WIDTH]),
            .cand     (cand[i])
         );
      end
   endgenerate

   // First asserted request at or after ptr, scanning with wrap-around.
   logic [PW:0]   idx;
   logic [PW-1:0] sel;
   always_comb begin
      gnt_found = 1'b0;
      gnt_nx    = '0;
      idx       = '0;
      sel       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + (PW+1)'(k);
         if (idx >= (PW+1)'(NUM_REQ))
            idx = idx - (PW+1)'(NUM_REQ);
         sel = idx[PW-1:0];
         if (!gnt_found && req[sel]) begin
            gnt_found = 1'b1;
            gnt_nx    = sel;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (gnt_found) state_nx = ISSUE;
         ISSUE:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign address = 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ptr        <= '0;
         gnt        <= '0;
         shadow     <= '0;
         ack        <= '0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         writedata  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         busy       <= (state_nx != IDLE);
         // strobe and ack are single-cycle; default them off every edge
         ack        <= '0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         case (state)
            IDLE: begin
               if (gnt_found) begin
                  gnt        <= gnt_nx;
                  shadow     <= cand[gnt_nx];
                  writedata  <= 32'(cand[gnt_nx]);
                  chipselect <= 1'b1;
                  write_n    <= 1'b0;
               end
            end
            ISSUE: ack[gnt] <= 1'b1;
            DONE: begin
               if (gnt == PW'(NUM_REQ-1)) ptr <= '0;
               else                       ptr <= gnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_led_write_arbiter.sv
module tb_led_write_arbiter;
   localparam int N = 7;
   localparam int W = 18;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [N-1:0]         req;
   logic [N*W-1:0]       set_mask, clr_mask;
   logic [N-1:0]         ack;
   logic [1:0]           address;
   logic                 chipselect, write_n;
   logic [31:0]          writedata;
   logic [W-1:0]         shadow;
   logic                 busy;

   led_write_arbiter #(.NUM_REQ(N), .LED_WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .set_mask(set_mask),
      .clr_mask(clr_mask), .ack(ack), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .shadow(shadow), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          core;
      logic [31:0] data;
   } exp_t;

   exp_t   exp_q[$];
   int     strobe_cyc[$];
   int     cyc = 0;
   int     pass_cnt = 0;
   int     chk_cnt = 0;

   // reference state: LED image and round-robin pointer
   logic [W-1:0] m_shadow;
   int           m_ptr;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
   endtask

   // Monitor: pops the scoreboard on every write strobe, then checks the
   // ack one cycle later and the busy window length.
   int  ack_core = -1;
   int  busy_run = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         ack_core = -1;
         busy_run = 0;
      end else begin
         if (ack_core >= 0) begin
            chk("ack_pulse", 32'(ack), 32'(1) << ack_core);
            ack_core = -1;
         end else if (ack != '0) begin
            chk("spurious_ack", 32'(ack), 32'h0);
         end
         if (chipselect && !write_n) begin
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", 32'h1, 32'h0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("writedata", writedata, e.data);
               chk("shadow", 32'(shadow), e.data);
               chk("address", 32'(address), 32'h0);
               ack_core = e.core;
            end
         end else if (chipselect || !write_n) begin
            chk("strobe_pair", {30'b0, chipselect, write_n}, 32'h1);
         end
         if (busy) busy_run++;
         else if (busy_run > 0) begin
            chk("busy_len", 32'(busy_run), 32'd2);
            busy_run = 0;
         end
      end
   end

   task automatic put_masks(input int c, input logic [W-1:0] s, input logic [W-1:0] cl);
      set_mask[c*W +: W] = s;
      clr_mask[c*W +: W] = cl;
   endtask

   // Issue one batch: all cores in s raise req together and each drops it
   // after its own ack. Expected order is round-robin distance from m_ptr.
   task automatic run_batch(input logic [N-1:0] s, input bit drop_in_issue);
      int raise_cyc, first_idx, left;
      for (int k = 0; k < N; k++) begin
         int c;
         exp_t e;
         c = (m_ptr + k) % N;
         if (s[c]) begin
            m_shadow = (m_shadow & ~clr_mask[c*W +: W]) | set_mask[c*W +: W];
            e.core = c;
            e.data = 32'(m_shadow);
            exp_q.push_back(e);
            left = c;
         end
      end
      m_ptr = (left + 1) % N;
      @(negedge clk);
      first_idx = strobe_cyc.size();
      raise_cyc = cyc;
      req = s;
      for (int t = 0; t < 10 * N && req != '0; t++) begin
         @(negedge clk);
         #1;
         if (drop_in_issue && chipselect) req = '0;
         req = req & ~ack;
      end
      if (req != '0) begin
         chk("batch_timeout", 32'(req), 32'h0);
         req = '0;
      end
      if (strobe_cyc.size() > first_idx)
         chk("first_latency", 32'(strobe_cyc[first_idx] - raise_cyc), 32'd1);
      else
         chk("no_strobe", 32'h0, 32'h1);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req = '0;
      m_shadow = '0;
      m_ptr = 0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      req = '0; set_mask = '0; clr_mask = '0;
      do_reset();
      #1;
      chk("rst_chipselect", 32'(chipselect), 32'h0);
      chk("rst_write_n", 32'(write_n), 32'h1);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_shadow", 32'(shadow), 32'h0);
      chk("rst_writedata", writedata, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      // single write, set only
      put_masks(2, 18'h0000F, 18'h0);
      run_batch(7'b0000100, 1'b0);
      chk("t1_shadow", 32'(shadow), 32'h0000F);

      // all on, then clear nibble 1 while setting bit 4
      put_masks(0, 18'h3FFFF, 18'h0);
      run_batch(7'b0000001, 1'b0);
      put_masks(4, 18'h00010, 18'h000F0);
      run_batch(7'b0010000, 1'b0);
      chk("t2_shadow", 32'(shadow), 32'h3FF1F);

      // every core at once: strobes three cycles apart
      for (int c = 0; c < N; c++) put_masks(c, 18'(1 << c), 18'(1 << (c + 8)));
      begin
         int base;
         base = strobe_cyc.size();
         run_batch(7'b1111111, 1'b0);
         for (int k = 1; k < N; k++)
            chk("t3_spacing", 32'(strobe_cyc[base+k] - strobe_cyc[base+k-1]), 32'd3);
      end

      // pointer at 5, cores 1 and 6 together: wrap grants 6 first
      put_masks(4, 18'h00100, 18'h0);
      run_batch(7'b0010000, 1'b0);
      put_masks(1, 18'h00002, 18'h3FFFF);
      put_masks(6, 18'h20000, 18'h00001);
      run_batch(7'b1000010, 1'b0);
      chk("t4_shadow", 32'(shadow), 32'h00002);

      // reset during ISSUE aborts the write
      put_masks(3, 18'h0AAAA, 18'h0);
      begin
         exp_t e;
         e.core = 3;
         e.data = 32'((m_shadow) | 18'h0AAAA);
         exp_q.push_back(e);
      end
      @(negedge clk);
      req = 7'b0001000;
      for (int t = 0; t < 10 && !(chipselect && !write_n); t++) @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("t5_chipselect", 32'(chipselect), 32'h0);
      chk("t5_write_n", 32'(write_n), 32'h1);
      chk("t5_shadow", 32'(shadow), 32'h0);
      chk("t5_q_drained", 32'(exp_q.size()), 32'h0);
      do_reset();
      repeat (3) begin
         @(negedge clk);
         chk("t5_no_ack", 32'(ack), 32'h0);
      end
      put_masks(5, 18'h00321, 18'h0);
      run_batch(7'b0100000, 1'b0);
      chk("t5_after", 32'(shadow), 32'h00321);

      // request withdrawn in ISSUE still completes
      put_masks(3, 18'h01000, 18'h00001);
      run_batch(7'b0001000, 1'b1);

      // randomized batches
      for (int b = 0; b < 40; b++) begin
         logic [N-1:0] s;
         for (int c = 0; c < N; c++)
            put_masks(c, 18'($urandom) & 18'($urandom), 18'($urandom));
         s = 7'($urandom_range(1, (1 << N) - 1));
         run_batch(s, 1'($urandom_range(0, 1)) && ($countones(s) == 1));
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end
endmodule
